// File: rtl/cv32e41s_rvfi_trace_buffer.sv
// Multi-retire RVFI trace capture buffer: compacts up to NRET retirements per cycle into a circular buffer.
// Latency: a retirement is visible on rd_data_o / count_o one cycle later; read data is combinational.
// Backpressure: none toward the core; stop mode discards retirements when full, wrap mode overwrites the oldest.
module cv32e41s_rvfi_trace_buffer #(
  parameter  int NRET    = 2,
  parameter  int DEPTH   = 16,
  localparam int ENTRY_W = 109,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NRET-1:0]      rvfi_valid_i,
  input  logic [32*NRET-1:0]   rvfi_pc_rdata_i,
  input  logic [5*NRET-1:0]    rvfi_rd_addr_i,
  input  logic [32*NRET-1:0]   rvfi_rd_wdata_i,
  input  logic [32*NRET-1:0]   rvfi_mem_addr_i,
  input  logic [4*NRET-1:0]    rvfi_mem_rmask_i,
  input  logic [4*NRET-1:0]    rvfi_mem_wmask_i,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic                 wrap_mode_i,
  input  logic                 trig_en_i,
  input  logic [31:0]          trig_pc_i,
  input  logic [CW-1:0]        post_trig_i,
  output logic                 rd_valid_o,
  output logic [ENTRY_W-1:0]   rd_data_o,
  input  logic                 rd_ready_i,
  output logic [CW-1:0]        count_o,
  output logic [1:0]           state_o,
  output logic                 triggered_o,
  output logic                 overflow_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      remaining_q;
  logic               triggered_q, overflow_q;

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [ENTRY_W-1:0] entry   [NRET];
  logic [PW-1:0]      wr_slot [NRET];
  logic [NRET-1:0]    wr_en;
  logic               pop;
  logic               capture;
  logic               post_phase;
  logic               trig_hit;
  logic               drop_over;
  logic [CW-1:0]      free;
  logic [CW-1:0]      n_wr;
  logic [CW-1:0]      excess;
  logic [CW-1:0]      rem_d;

  // Capture datapath: pop first, then compact valid channels in order, applying trigger and space limits.
  always_comb begin
    pop        = (count_q != '0) && rd_ready_i;
    free       = CW'(DEPTH) - count_q + CW'(pop);
    capture    = ((state_q == ARMED) || (state_q == POST)) && !start_i && !clear_i;
    n_wr       = '0;
    trig_hit   = 1'b0;
    drop_over  = 1'b0;
    rem_d      = remaining_q;
    wr_en      = '0;
    for (int i = 0; i < NRET; i++) begin
      entry[i]   = {rvfi_pc_rdata_i[32*i +: 32], rvfi_rd_addr_i[5*i +: 5],
                    rvfi_rd_wdata_i[32*i +: 32], rvfi_mem_rmask_i[4*i +: 4],
                    rvfi_mem_wmask_i[4*i +: 4], rvfi_mem_addr_i[32*i +: 32]};
      wr_slot[i] = '0;
    end
    for (int i = 0; i < NRET; i++) begin
      post_phase = (state_q == POST) || trig_hit;
      if (capture && rvfi_valid_i[i]) begin
        if (post_phase && (rem_d == '0)) begin
          // Post-trigger window exhausted: dropped silently, not an overflow.
        end else if (!wrap_mode_i && (n_wr == free)) begin
          drop_over = 1'b1;
        end else begin
          wr_en[i]   = 1'b1;
          wr_slot[i] = wr_ptr_q + PW'(n_wr);
          n_wr       = n_wr + CW'(1);
          if (post_phase) begin
            rem_d = rem_d - CW'(1);
          end else if ((state_q == ARMED) && trig_en_i &&
                       (rvfi_pc_rdata_i[32*i +: 32] == trig_pc_i)) begin
            trig_hit = 1'b1;
            rem_d    = post_trig_i;
          end
        end
      end
    end
    post_phase = (state_q == POST) || trig_hit;
    excess     = (wrap_mode_i && (n_wr > free)) ? (n_wr - free) : '0;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: control pulses first, then stop-mode full, window exhausted, or fresh trigger.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      state_d = ARMED;
    end else if (capture) begin
      if (!wrap_mode_i && (drop_over || ((n_wr != '0) && (n_wr == free)))) begin
        state_d = DONE;
      end else if (post_phase && (rem_d == '0)) begin
        state_d = DONE;
      end else if (trig_hit) begin
        state_d = POST;
      end
    end
  end

  // Pointers, occupancy, post-trigger budget and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (clear_i || start_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + PW'(n_wr);
      rd_ptr_q    <= rd_ptr_q + PW'(pop) + PW'(excess);
      count_q     <= count_q - CW'(pop) + n_wr - excess;
      remaining_q <= rem_d;
      if (trig_hit) begin
        triggered_q <= 1'b1;
      end
      if (drop_over || (excess != '0)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Entry storage; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++) begin
      if (wr_en[i]) begin
        mem[wr_slot[i]] <= entry[i];
      end
    end
  end

  // Outputs.
  always_comb begin
    rd_valid_o  = (count_q != '0);
    rd_data_o   = mem[rd_ptr_q];
    count_o     = count_q;
    state_o     = state_q;
    triggered_o = triggered_q;
    overflow_o  = overflow_q;
  end

endmodule

// File: tb/tb_cv32e41s_rvfi_trace_buffer.sv
// Bench for the RVFI trace buffer: expected entries queued at retirement, compared when popped.
module tb_cv32e41s_rvfi_trace_buffer;

  localparam int NRET    = 2;
  localparam int DEPTH   = 16;
  localparam int ENTRY_W = 109;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [NRET-1:0]     rvfi_valid_i = '0;
  logic [32*NRET-1:0]  rvfi_pc_rdata_i = '0;
  logic [5*NRET-1:0]   rvfi_rd_addr_i = '0;
  logic [32*NRET-1:0]  rvfi_rd_wdata_i = '0;
  logic [32*NRET-1:0]  rvfi_mem_addr_i = '0;
  logic [4*NRET-1:0]   rvfi_mem_rmask_i = '0;
  logic [4*NRET-1:0]   rvfi_mem_wmask_i = '0;
  logic                start_i = 1'b0;
  logic                clear_i = 1'b0;
  logic                wrap_mode_i = 1'b0;
  logic                trig_en_i = 1'b0;
  logic [31:0]         trig_pc_i = '0;
  logic [CW-1:0]       post_trig_i = '0;
  logic                rd_valid_o;
  logic [ENTRY_W-1:0]  rd_data_o;
  logic                rd_ready_i = 1'b0;
  logic [CW-1:0]       count_o;
  logic [1:0]          state_o;
  logic                triggered_o;
  logic                overflow_o;

  int checks = 0;
  int errors = 0;
  logic [ENTRY_W-1:0] sb_q [$];

  cv32e41s_rvfi_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
    .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
    .rvfi_mem_addr_i(rvfi_mem_addr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
    .rvfi_mem_wmask_i(rvfi_mem_wmask_i),
    .start_i(start_i), .clear_i(clear_i), .wrap_mode_i(wrap_mode_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .post_trig_i(post_trig_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .count_o(count_o), .state_o(state_o),
    .triggered_o(triggered_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Layout {pc, rd_addr, rd_wdata, rmask, wmask, mem_addr}, pc in the MSBs.
  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [31:0] pc);
    return {pc, pc[6:2], ~pc, pc[5:2], pc[7:4], pc ^ 32'hA5A5_0000};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] pc);
    logic [ENTRY_W-1:0] e;
    e = mk_entry(pc);
    rvfi_pc_rdata_i[32*ch +: 32] = pc;
    rvfi_rd_addr_i[5*ch +: 5]    = pc[6:2];
    rvfi_rd_wdata_i[32*ch +: 32] = ~pc;
    rvfi_mem_rmask_i[4*ch +: 4]  = pc[5:2];
    rvfi_mem_wmask_i[4*ch +: 4]  = pc[7:4];
    rvfi_mem_addr_i[32*ch +: 32] = pc ^ 32'hA5A5_0000;
    if (e[ENTRY_W-1 -: 32] != pc) $display("bench layout inconsistency");
  endtask

  // One retire cycle; exp0/exp1 say whether the bench expects each channel to be captured.
  task automatic retire(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                        input bit exp0, input bit exp1);
    set_ch(0, pc0);
    set_ch(1, pc1);
    rvfi_valid_i = v;
    if (v[0] && exp0) sb_q.push_back(mk_entry(pc0));
    if (v[1] && exp1) sb_q.push_back(mk_entry(pc1));
    tick();
    rvfi_valid_i = '0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    rd_ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!rd_valid_o) break;
      if (sb_q.size() == 0) begin
        chk({tag, "_extra"}, rd_valid_o, 1'b0);
        break;
      end
      chk({tag, "_data"}, rd_data_o, sb_q.pop_front());
      tick();
    end
    rd_ready_i = 1'b0;
    chk({tag, "_left"}, sb_q.size(), 0);
    chk({tag, "_empty"}, rd_valid_o, 1'b0);
    sb_q.delete();
  endtask

  initial begin
    // Reset values.
    tick();
    tick();
    chk("rst_count", count_o, 0);
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_trig", triggered_o, 0);
    chk("rst_ovf", overflow_o, 0);
    rst_ni = 1'b1;
    tick();

    // Basic capture: 3 cycles of two retirements.
    pulse_start();
    chk("t1_state", state_o, 1);
    for (int c = 0; c < 3; c++) retire(2'b11, 32'h100 + 8*c, 32'h104 + 8*c, 1, 1);
    chk("t1_count", count_o, 6);
    drain("t1");

    // Stop mode: exact fill then ignored cycle.
    pulse_start();
    for (int c = 0; c < 8; c++) retire(2'b11, 32'h300 + 8*c, 32'h304 + 8*c, 1, 1);
    chk("t2_count", count_o, 16);
    chk("t2_state", state_o, 3);
    chk("t2_ovf", overflow_o, 0);
    retire(2'b11, 32'h380, 32'h384, 0, 0);
    chk("t2_count9", count_o, 16);
    drain("t2");

    // Stop mode with 17 valid retirements: last one discarded.
    pulse_start();
    for (int c = 0; c < 7; c++) retire(2'b11, 32'h400 + 8*c, 32'h404 + 8*c, 1, 1);
    retire(2'b01, 32'h438, 32'h0, 1, 0);
    chk("t2b_state_mid", state_o, 1);
    retire(2'b11, 32'h43C, 32'h440, 1, 0);
    chk("t2b_ovf", overflow_o, 1);
    chk("t2b_state", state_o, 3);
    chk("t2b_count", count_o, 16);
    drain("t2b");

    // Wrap mode: 20 single retirements, oldest four lost.
    wrap_mode_i = 1'b1;
    pulse_start();
    for (int c = 0; c < 20; c++) retire(2'b01, 32'(4*c), 32'h0, c >= 4, 0);
    chk("t3_count", count_o, 16);
    chk("t3_ovf", overflow_o, 1);
    chk("t3_state", state_o, 1);
    drain("t3");

    // Full in ARMED, switch to stop mode, pop and retire together.
    pulse_start();
    for (int c = 0; c < 16; c++) retire(2'b01, 32'h500 + 4*c, 32'h0, 1, 0);
    chk("t4_count_full", count_o, 16);
    chk("t4_ovf0", overflow_o, 0);
    wrap_mode_i = 1'b0;
    rd_ready_i  = 1'b1;
    chk("t4_pop_data", rd_data_o, sb_q.pop_front());
    retire(2'b01, 32'h600, 32'h0, 1, 0);
    rd_ready_i  = 1'b0;
    chk("t4_count", count_o, 16);
    chk("t4_state", state_o, 3);
    chk("t4_ovf", overflow_o, 0);
    drain("t4");

    // clear_i wins over start_i.
    pulse_start();
    retire(2'b11, 32'h700, 32'h704, 0, 0);
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    chk("t5_state", state_o, 0);
    chk("t5_count", count_o, 0);
    retire(2'b11, 32'h710, 32'h714, 0, 0);
    chk("t5_idle_count", count_o, 0);

    // Trigger with post depth 3.
    trig_en_i   = 1'b1;
    trig_pc_i   = 32'h200;
    post_trig_i = CW'(3);
    pulse_start();
    retire(2'b11, 32'h1F0, 32'h1F4, 1, 1);
    chk("t6_trig_pre", triggered_o, 0);
    retire(2'b11, 32'h200, 32'h204, 1, 1);
    chk("t6_state_post", state_o, 2);
    chk("t6_trig", triggered_o, 1);
    retire(2'b11, 32'h208, 32'h20C, 1, 1);
    chk("t6_state_done", state_o, 3);
    retire(2'b11, 32'h210, 32'h200, 0, 0);
    chk("t6_count", count_o, 6);
    chk("t6_ovf", overflow_o, 0);
    drain("t6");

    // Trigger with zero post depth: later channel in the same cycle dropped.
    post_trig_i = CW'(0);
    pulse_start();
    retire(2'b11, 32'h200, 32'h204, 1, 0);
    chk("t7_state", state_o, 3);
    chk("t7_count", count_o, 1);
    chk("t7_ovf", overflow_o, 0);
    drain("t7");

    // Reset asserted mid-POST.
    post_trig_i = CW'(5);
    pulse_start();
    retire(2'b01, 32'h200, 32'h0, 0, 0);
    chk("t8_state_post", state_o, 2);
    rst_ni = 1'b0;
    tick();
    chk("t8_state", state_o, 0);
    chk("t8_count", count_o, 0);
    chk("t8_valid", rd_valid_o, 0);
    chk("t8_trig", triggered_o, 0);
    chk("t8_ovf", overflow_o, 0);
    rst_ni = 1'b1;
    sb_q.delete();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e41s_rvfi_trace_buffer.md
# cv32e41s_rvfi_trace_buffer

Synthesizable multi-retire RVFI trace capture buffer for the cv32e41s SoC environment. Sits on the core's RVFI port, packs up to NRET retirements per cycle into a DEPTH-entry circular buffer, and exposes them through a valid/ready read port for the debug or test subsystem. Supports stop-on-full and wrap (overwrite-oldest) modes plus a PC-match trigger with programmable post-trigger depth. Replaces file-based tracing in FPGA and silicon-proxy runs.

## Interface
- NRET, 2: retire channels per cycle; 1..4.
- DEPTH, 16: buffer entries; power of two, >= 4.
- ENTRY_W, 109 (localparam): entry = {pc[31:0], rd_addr[4:0], rd_wdata[31:0], mem_rmask[3:0], mem_wmask[3:0], mem_addr[31:0]}, pc in MSBs.
- CW = $clog2(DEPTH)+1 (localparam): count width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- rvfi_valid_i  in  NRET  per-channel retire valid; lower index is older.
- rvfi_pc_rdata_i  in  32*NRET  retired PC per channel.
- rvfi_rd_addr_i  in  5*NRET  rd address.
- rvfi_rd_wdata_i  in  32*NRET  rd write data.
- rvfi_mem_addr_i  in  32*NRET  memory address (lowest memory slot per channel only).
- rvfi_mem_rmask_i, rvfi_mem_wmask_i  in  4*NRET each  byte masks.
- start_i  in  1  pulse: clear pointers/flags, enter ARMED.
- clear_i  in  1  pulse: clear pointers/flags, enter IDLE; priority over start_i.
- wrap_mode_i  in  1  0 = stop-on-full, 1 = overwrite oldest. Sampled every cycle.
- trig_en_i  in  1  enable PC trigger.
- trig_pc_i  in  32  trigger PC.
- post_trig_i  in  CW  entries to capture after the trigger entry.
- rd_valid_o  out  1  buffer non-empty.
- rd_data_o  out  ENTRY_W  oldest entry.
- rd_ready_i  in  1  pop oldest when rd_valid_o.
- count_o  out  CW  occupied entries, 0..DEPTH.
- state_o  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- triggered_o  out  1  sticky: trigger seen since start.
- overflow_o  out  1  sticky: at least one retirement discarded or overwritten.

## Operation
- Reset: state IDLE, wr/rd pointers 0, count_o 0, rd_valid_o 0, rd_data_o don't-care (memory not reset), triggered_o 0, overflow_o 0.
- IDLE and DONE: no capture; reads still pop.
- start_i (any state): pointers, count, triggered_o, overflow_o to 0; state ARMED next cycle; same-cycle retirements ignored.
- ARMED/POST capture: valid channels compacted in index order into consecutive slots from wr_ptr; pointers wrap modulo DEPTH.
- Space accounting: a same-cycle pop is applied first; free = DEPTH - count + pop.
- Stop mode: if valid > free, write the lowest `free` channels, set overflow_o, go DONE. Exactly filling → DONE, overflow_o unchanged.
- Wrap mode: all valid channels written; excess over free advances rd_ptr by the excess (oldest lost), count saturates at DEPTH, overflow_o set.
- Trigger (ARMED, trig_en_i=1): lowest valid channel k with pc == trig_pc_i. Channels 0..k written, triggered_o set, remaining = post_trig_i. Channels after k in the same cycle count against remaining. Entries beyond remaining are dropped without setting overflow_o. remaining reaching 0 → DONE, else POST.
- POST: each written entry decrements remaining; reaching 0 → DONE. Stop-mode full also → DONE. PC matches in POST ignored.
- trig_en_i=0 in ARMED: capture continues until stop-mode full (DONE) or indefinitely in wrap mode.
- count_o = count + written - popped, never exceeds DEPTH.

## Timing
- Writes registered: entry visible on rd_data_o and counted in count_o the cycle after retirement.
- rd_data_o combinational from memory at rd_ptr; pop takes effect at clock edge.
- State, triggered_o, overflow_o update at the edge of the deciding cycle.
- Reset asserted mid-capture: immediate return to reset values, buffer contents abandoned.

## Test plan
- NRET=2, DEPTH=16, stop mode, start then 3 cycles of both channels valid (PCs 0x100..0x114) → count_o=6, pops return 0x100,0x104,…,0x114 in order.
- Stop mode, 9 cycles of 2 retirements → after 8th cycle count_o=16, state DONE, overflow_o=0; 9th ignored; stop with 17 valid → overflow_o=1.
- Wrap mode, 20 single retirements PC 0x0..0x4C → count_o=16, overflow_o=1, first pop returns PC 0x10.
- trig_pc_i=0x200, post_trig_i=3, both channels valid with ch0=0x200, ch1=0x204, then 0x208,0x20C → state DONE after 0x20C written, triggered_o=1, later retirements dropped, overflow_o=0.
- Full buffer in stop mode, pop and 1 retirement same cycle → count_o stays 16, entry written; clear_i with start_i → IDLE, count_o=0.
- Assert rst_ni low mid-POST → next observation all outputs at reset values, state IDLE.
